// File: rtl/hci_hwpe_port_arbiter_if.sv
// rtl/hci_hwpe_port_arbiter_if.sv - initiator-side and shared-port bus bundle of the HWPE port arbiter
//
// Purpose: groups the NB_REQ initiator request/response signals and the shared
// HWPE memory port signals. Signal names carry the direction seen by the arbiter.
//   in_req_i/in_wen_i/in_add_i/in_be_i/in_data_i : packed initiator requests
//   in_gnt_o/in_r_valid_o/in_r_data_o            : initiator grants and responses
//   out_req_o/out_wen_o/out_add_o/out_be_o/out_data_o : shared-port request
//   out_gnt_i/out_r_data_i/out_r_valid_i         : shared-port grant and response
// Modports: slave = arbiter view, master = environment driving the arbiter.
interface hci_hwpe_port_arbiter_if #(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned DW     = 128,
  parameter int unsigned AW     = 32,
  parameter int unsigned BW     = DW / 8
);
  logic [NB_REQ-1:0]    in_req_i;
  logic [NB_REQ-1:0]    in_gnt_o;
  logic [NB_REQ-1:0]    in_wen_i;
  logic [NB_REQ*AW-1:0] in_add_i;
  logic [NB_REQ*BW-1:0] in_be_i;
  logic [NB_REQ*DW-1:0] in_data_i;
  logic [DW-1:0]        in_r_data_o;
  logic [NB_REQ-1:0]    in_r_valid_o;
  logic                 out_req_o;
  logic                 out_gnt_i;
  logic                 out_wen_o;
  logic [AW-1:0]        out_add_o;
  logic [BW-1:0]        out_be_o;
  logic [DW-1:0]        out_data_o;
  logic [DW-1:0]        out_r_data_i;
  logic                 out_r_valid_i;

  modport slave (
    input  in_req_i, in_wen_i, in_add_i, in_be_i, in_data_i,
    output in_gnt_o, in_r_data_o, in_r_valid_o,
    output out_req_o, out_wen_o, out_add_o, out_be_o, out_data_o,
    input  out_gnt_i, out_r_data_i, out_r_valid_i
  );

  modport master (
    output in_req_i, in_wen_i, in_add_i, in_be_i, in_data_i,
    input  in_gnt_o, in_r_data_o, in_r_valid_o,
    input  out_req_o, out_wen_o, out_add_o, out_be_o, out_data_o,
    output out_gnt_i, out_r_data_i, out_r_valid_i
  );
endinterface

// File: rtl/hci_hwpe_port_arbiter.sv
// rtl/hci_hwpe_port_arbiter.sv - shares one wide HWPE memory port between NB_REQ initiators
//
// Purpose: round-robin arbiter with optional fixed priority for initiator 0,
// bounded by a starvation counter, and 1-cycle response steering back to the
// initiator that was granted.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clear_i : synchronous clear of all state (also drops a response arriving in that cycle)
//   hp_en_i : 1 = initiator 0 has priority, 0 = pure round-robin
//   bus     : initiator and shared-port signals (slave modport)
module hci_hwpe_port_arbiter #(
  parameter int unsigned NB_REQ    = 4,
  parameter int unsigned DW        = 128,
  parameter int unsigned AW        = 32,
  parameter int unsigned BW        = DW / 8,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   hp_en_i,
  hci_hwpe_port_arbiter_if.slave bus
);

  localparam int unsigned IW        = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned SW        = $clog2(MAX_STALL + 1);
  localparam logic [IW:0] NB_WRAP   = (IW + 1)'(NB_REQ);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  // (base + ofs) mod NB_REQ; both operands are already below NB_REQ so one
  // conditional subtraction is enough, also for non-power-of-two NB_REQ.
  function automatic logic [IW-1:0] f_wrap_add(input logic [IW-1:0] base,
                                               input logic [IW-1:0] ofs);
    logic [IW:0] v_sum;
    v_sum = {1'b0, base} + {1'b0, ofs};
    if (v_sum >= NB_WRAP) v_sum = v_sum - NB_WRAP;
    return v_sum[IW-1:0];
  endfunction

  logic [IW-1:0] r_rr_ptr;
  logic [SW-1:0] r_stall_cnt;
  logic [IW-1:0] r_rsp_id;
  logic          r_rsp_pend;

  logic          w_out_req;
  logic          w_any_lo;
  logic          w_force;
  logic          w_hp;
  logic          w_hs;
  logic [IW-1:0] w_rr_sel;
  logic [IW-1:0] w_force_sel;
  logic [IW-1:0] w_sel;

  assign w_out_req     = |bus.in_req_i;
  assign bus.out_req_o = w_out_req;
  assign w_any_lo      = |bus.in_req_i[NB_REQ-1:1];

  // Initiator 0 has been holding off the others for MAX_STALL cycles: give
  // one slot to the round-robin order among initiators 1..NB_REQ-1.
  assign w_force = hp_en_i & (r_stall_cnt == STALL_MAX) & w_any_lo;
  assign w_hp    = hp_en_i & bus.in_req_i[0] & ~w_force;
  assign w_hs    = w_out_req & bus.out_gnt_i;

  // Scan from the farthest offset down so the nearest requester at or after
  // r_rr_ptr is the last assignment and wins. With no requester both stay at
  // r_rr_ptr, which keeps the payload mux on a stable index.
  always_comb begin
    logic [IW-1:0] v_idx;
    v_idx       = '0;
    w_rr_sel    = r_rr_ptr;
    w_force_sel = r_rr_ptr;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      v_idx = f_wrap_add(r_rr_ptr, IW'(k));
      if (bus.in_req_i[v_idx]) begin
        w_rr_sel = v_idx;
        if (v_idx != '0) w_force_sel = v_idx;
      end
    end
  end

  always_comb begin
    w_sel = w_rr_sel;
    if (w_force)   w_sel = w_force_sel;
    else if (w_hp) w_sel = '0;
  end

  // Payload mux and one-hot grant / response steering.
  always_comb begin
    bus.out_wen_o    = 1'b0;
    bus.out_add_o    = '0;
    bus.out_be_o     = '0;
    bus.out_data_o   = '0;
    bus.in_gnt_o     = '0;
    bus.in_r_valid_o = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (w_sel == IW'(i)) begin
        bus.out_wen_o  = bus.in_wen_i[i];
        bus.out_add_o  = bus.in_add_i[i*AW +: AW];
        bus.out_be_o   = bus.in_be_i[i*BW +: BW];
        bus.out_data_o = bus.in_data_i[i*DW +: DW];
      end
      bus.in_gnt_o[i]     = w_hs & (w_sel == IW'(i));
      // A clear in the response cycle discards the outstanding response.
      bus.in_r_valid_o[i] = bus.out_r_valid_i & r_rsp_pend & ~clear_i &
                            (r_rsp_id == IW'(i));
    end
  end

  assign bus.in_r_data_o = bus.out_r_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
      r_rsp_id    <= '0;
      r_rsp_pend  <= 1'b0;
    end else if (clear_i) begin
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
      r_rsp_id    <= '0;
      r_rsp_pend  <= 1'b0;
    end else begin
      r_rsp_pend <= w_hs;
      r_rsp_id   <= w_sel;

      // Priority grants to initiator 0 do not consume a round-robin slot.
      if (w_hs && !w_hp) r_rr_ptr <= f_wrap_add(w_sel, IW'(1));

      // Counts cycles in which initiator 0 wins while others wait, whether
      // or not the shared port grants; only serving another initiator resets it.
      if (!hp_en_i) begin
        r_stall_cnt <= '0;
      end else if (w_hs && !w_hp && (w_sel != '0)) begin
        r_stall_cnt <= '0;
      end else if (w_hp && w_any_lo && (r_stall_cnt != STALL_MAX)) begin
        r_stall_cnt <= r_stall_cnt + SW'(1);
      end
    end
  end

endmodule
